// File: rtl/am_insert_ctrl.sv
// am_insert_ctrl: TX-side alignment-marker scheduler.
// Emits one AM per PCS lane (lanes 0..3, in order) before every group of
// 4*AM_PERIOD data blocks. Data blocks pass straight through with zero
// latency, and every output block is tagged with its round-robin lane.
module am_insert_ctrl #(
    parameter int AM_PERIOD = 16383,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [49:0]      data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [49:0]      data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       lane_id,
    output logic             am_insert,
    output logic [CNT_W-1:0] blk_cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INSERT = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Count of the last data block in a group; its transfer starts the next AM group.
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(4 * AM_PERIOD - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_am_idx;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [1:0]       r_lane_id;
    logic             w_xfer;
    logic             w_last_am;
    logic             w_last_blk;

    // Marker for one lane: sync header 01, then bytes M0..M5 from LSB upward.
    function automatic logic [49:0] amPattern(input logic [1:0] idx);
        logic [49:0] pattern;
        case (idx)
            2'd0:    pattern = {8'hB8, 8'h89, 8'h6F, 8'h47, 8'h76, 8'h90, 2'b01};
            2'd1:    pattern = {8'h19, 8'h3B, 8'h0F, 8'hE6, 8'hC4, 8'hF0, 2'b01};
            2'd2:    pattern = {8'h64, 8'h9A, 8'h3A, 8'h9B, 8'h65, 8'hC5, 2'b01};
            default: pattern = {8'hC2, 8'h86, 8'h5D, 8'h3D, 8'h79, 8'hA2, 2'b01};
        endcase
        return pattern;
    endfunction

    assign w_xfer      = out_valid && out_ready;
    assign w_last_am   = (r_am_idx == 2'd3);
    assign w_last_blk  = (r_blk_cnt == LAST_BLK);
    assign lane_id     = r_lane_id;
    assign blk_cnt_out = r_blk_cnt;

    // State register; reset drops any partially sent AM group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE so a restart begins with a full AM group.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_INSERT;
                end
                ST_INSERT: begin
                    if (out_ready && w_last_am) begin
                        w_next_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer && w_last_blk) begin
                        w_next_state = ST_INSERT;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; the DATA path is combinational so pass-through adds no latency.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        am_insert = 1'b0;
        data_out  = '0;
        case (r_state)
            ST_INSERT: begin
                out_valid = 1'b1;
                am_insert = 1'b1;
                data_out  = amPattern(r_am_idx);
            end
            ST_DATA: begin
                data_out  = data_in;
                out_valid = in_valid;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    // Marker index, block counter and lane tag; all advance only on an actual output transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_am_idx  <= 2'd0;
            r_blk_cnt <= '0;
            r_lane_id <= 2'd0;
        end else if (!enable) begin
            r_am_idx  <= 2'd0;
            r_blk_cnt <= '0;
            r_lane_id <= 2'd0;
        end else begin
            case (r_state)
                ST_INSERT: begin
                    if (out_ready) begin
                        r_am_idx  <= r_am_idx + 2'd1;
                        r_lane_id <= r_lane_id + 2'd1;
                        if (w_last_am) begin
                            r_blk_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_lane_id <= r_lane_id + 2'd1;
                        if (w_last_blk) begin
                            r_blk_cnt <= '0;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_am_idx  <= 2'd0;
                    r_blk_cnt <= '0;
                    r_lane_id <= 2'd0;
                end
            endcase
        end
    end

endmodule
